// File: rtl/post_dbg_probe_if.sv
// ----------------------------------------------------------------------------
// post_dbg_probe_if
//   Bundles the monitored buses, capture controls and probe outputs of
//   post_dbg_probe. Clock and reset are not part of the bundle.
//
//   master : drives CH_W/CH_N/SEL/ARM/CLR/TRIG_VAL/TRIG_MSK/POST/RD_IDX,
//            observes OUT_W/OUT_N/STATE/HIT_CNT/RD_W/RD_N
//   slave  : the probe itself (directions reversed)
//
//   CH_W     N_CH*W_W  wide buses, channel k at [k*W_W +: W_W]
//   CH_N     N_CH*N_W  narrow buses, channel k at [k*N_W +: N_W]
//   SEL      SEL_W     channel select
//   ARM      1         arm request (level)
//   CLR      1         abort capture, back to IDLE
//   TRIG_VAL W_W       trigger compare value
//   TRIG_MSK W_W       trigger mask, 1 = bit compared
//   POST     CNT_W     samples stored after the trigger sample
//   RD_IDX   DEPTH_W   history read index, 0 = newest
//   OUT_W    W_W       probe wide output
//   OUT_N    N_W       probe narrow output
//   STATE    2         00 IDLE, 01 ARMED, 10 POST, 11 FROZEN
//   HIT_CNT  CNT_W     saturating trigger count
//   RD_W     W_W       history wide readout
//   RD_N     N_W       history narrow readout
// ----------------------------------------------------------------------------
interface post_dbg_probe_if #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned W_W     = 8,
    parameter int unsigned N_W     = 3,
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned CNT_W   = 4
);
    localparam int unsigned N_CH = 2 ** SEL_W;

    logic [N_CH*W_W-1:0] CH_W;
    logic [N_CH*N_W-1:0] CH_N;
    logic [SEL_W-1:0]    SEL;
    logic                ARM;
    logic                CLR;
    logic [W_W-1:0]      TRIG_VAL;
    logic [W_W-1:0]      TRIG_MSK;
    logic [CNT_W-1:0]    POST;
    logic [DEPTH_W-1:0]  RD_IDX;
    logic [W_W-1:0]      OUT_W;
    logic [N_W-1:0]      OUT_N;
    logic [1:0]          STATE;
    logic [CNT_W-1:0]    HIT_CNT;
    logic [W_W-1:0]      RD_W;
    logic [N_W-1:0]      RD_N;

    modport master (
        output CH_W, CH_N, SEL, ARM, CLR, TRIG_VAL, TRIG_MSK, POST, RD_IDX,
        input  OUT_W, OUT_N, STATE, HIT_CNT, RD_W, RD_N
    );

    modport slave (
        input  CH_W, CH_N, SEL, ARM, CLR, TRIG_VAL, TRIG_MSK, POST, RD_IDX,
        output OUT_W, OUT_N, STATE, HIT_CNT, RD_W, RD_N
    );
endinterface

// File: rtl/post_dbg_probe.sv
// ----------------------------------------------------------------------------
// post_dbg_probe
//   Debug probe for the Post system. Selects one of N_CH monitored bus pairs
//   (wide + narrow) for a live registered view, and offers an armed capture:
//   masked-compare trigger, programmable post-trigger depth, a DEPTH-entry
//   history buffer and a saturating hit counter.
//
//   CLK  in  system clock, all state on rising edge
//   RST  in  synchronous reset, active-high
//   bus  slave modport of post_dbg_probe_if (buses, controls, outputs)
// ----------------------------------------------------------------------------
module post_dbg_probe #(
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned W_W     = 8,
    parameter int unsigned N_W     = 3,
    parameter int unsigned DEPTH_W = 2,
    parameter int unsigned CNT_W   = 4
) (
    input logic              CLK,
    input logic              RST,
    post_dbg_probe_if.slave  bus
);
    localparam int unsigned DEPTH = 2 ** DEPTH_W;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ARMED  = 2'b01,
        S_POST   = 2'b10,
        S_FROZEN = 2'b11
    } state_t;

    state_t               state_q, state_d;
    logic [W_W-1:0]       samp_w_q, samp_w_d;
    logic [N_W-1:0]       samp_n_q, samp_n_d;
    logic [W_W-1:0]       trig_w_q, trig_w_d;
    logic [N_W-1:0]       trig_n_q, trig_n_d;
    logic [DEPTH_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [W_W-1:0]       out_w_q, out_w_d;
    logic [N_W-1:0]       out_n_q, out_n_d;
    logic [W_W-1:0]       rd_w_q;
    logic [N_W-1:0]       rd_n_q;
    logic [W_W-1:0]       hist_w_q [DEPTH];
    logic [N_W-1:0]       hist_n_q [DEPTH];
    logic                 wr_en;
    logic                 hit;
    logic [DEPTH_W-1:0]   rd_ptr;

    // Trigger compares the already-registered sample, so the stored trigger
    // sample and the history write of that cycle are the same value.
    assign hit    = (((samp_w_q ^ bus.TRIG_VAL) & bus.TRIG_MSK) == '0);
    // wr_ptr points at the next free slot, so newest entry is wr_ptr-1.
    assign rd_ptr = wr_ptr_q - DEPTH_W'(1) - bus.RD_IDX;

    always_comb begin
        samp_w_d  = bus.CH_W[bus.SEL*W_W +: W_W];
        samp_n_d  = bus.CH_N[bus.SEL*N_W +: N_W];
        state_d   = state_q;
        trig_w_d  = trig_w_q;
        trig_n_d  = trig_n_q;
        wr_ptr_d  = wr_ptr_q;
        cnt_d     = cnt_q;
        hit_cnt_d = hit_cnt_q;
        wr_en     = 1'b0;

        if (bus.CLR) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.ARM) begin
                        state_d  = S_ARMED;
                        wr_ptr_d = '0;
                    end
                end
                S_ARMED: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
                    if (hit) begin
                        trig_w_d  = samp_w_q;
                        trig_n_d  = samp_n_q;
                        hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
                        cnt_d     = bus.POST;
                        state_d   = (bus.POST == '0) ? S_FROZEN : S_POST;
                    end
                end
                S_POST: begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + DEPTH_W'(1);
                    cnt_d    = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_FROZEN;
                    end
                end
                S_FROZEN: begin
                    if (bus.ARM) begin
                        state_d  = S_ARMED;
                        wr_ptr_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Output view follows the current state register, so a state change
        // shows on OUT_W/OUT_N one cycle later.
        if (state_q == S_POST || state_q == S_FROZEN) begin
            out_w_d = trig_w_q;
            out_n_d = trig_n_q;
        end else begin
            out_w_d = samp_w_q;
            out_n_d = samp_n_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            samp_w_q  <= '0;
            samp_n_q  <= '0;
            trig_w_q  <= '0;
            trig_n_q  <= '0;
            wr_ptr_q  <= '0;
            cnt_q     <= '0;
            hit_cnt_q <= '0;
            out_w_q   <= '0;
            out_n_q   <= '0;
            rd_w_q    <= '0;
            rd_n_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist_w_q[i] <= '0;
                hist_n_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            samp_w_q  <= samp_w_d;
            samp_n_q  <= samp_n_d;
            trig_w_q  <= trig_w_d;
            trig_n_q  <= trig_n_d;
            wr_ptr_q  <= wr_ptr_d;
            cnt_q     <= cnt_d;
            hit_cnt_q <= hit_cnt_d;
            out_w_q   <= out_w_d;
            out_n_q   <= out_n_d;
            rd_w_q    <= hist_w_q[rd_ptr];
            rd_n_q    <= hist_n_q[rd_ptr];
            if (wr_en) begin
                hist_w_q[wr_ptr_q] <= samp_w_q;
                hist_n_q[wr_ptr_q] <= samp_n_q;
            end
        end
    end

    assign bus.OUT_W   = out_w_q;
    assign bus.OUT_N   = out_n_q;
    assign bus.STATE   = state_q;
    assign bus.HIT_CNT = hit_cnt_q;
    assign bus.RD_W    = rd_w_q;
    assign bus.RD_N    = rd_n_q;
endmodule

// File: tb/tb_post_dbg_probe.sv
module tb_post_dbg_probe;
    logic CLK = 1'b0;
    logic RST;

    post_dbg_probe_if bus ();

    post_dbg_probe #(
        .SEL_W  (3),
        .W_W    (8),
        .N_W    (3),
        .DEPTH_W(2),
        .CNT_W  (4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned exp_hits;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: got %0h expected none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val)
            else begin
                n_err++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    initial begin
        bus.CH_W = '0; bus.CH_N = '0; bus.SEL = '0; bus.ARM = 1'b0; bus.CLR = 1'b0;
        bus.TRIG_VAL = '0; bus.TRIG_MSK = '0; bus.POST = '0; bus.RD_IDX = '0;

        // T1 reset with random inputs
        RST = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.CH_W = {$urandom, $urandom};
            bus.CH_N = 24'($urandom);
            bus.SEL = 3'($urandom);
            bus.ARM = 1'($urandom);
            bus.CLR = 1'($urandom);
            bus.TRIG_VAL = 8'($urandom);
            bus.TRIG_MSK = 8'($urandom);
            bus.POST = 4'($urandom);
            tick();
        end
        push_exp("rst_state", 0); check(32'(bus.STATE));
        push_exp("rst_out_w", 0); check(32'(bus.OUT_W));
        push_exp("rst_hit_cnt", 0); check(32'(bus.HIT_CNT));
        RST = 1'b0; bus.ARM = 1'b0; bus.CLR = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.RD_IDX = 2'(i);
            push_exp($sformatf("rst_rd_w%0d", i), 0);
            tick();
            check(32'(bus.RD_W));
        end

        // T2 live mux
        bus.SEL = 3'd5; bus.CH_W[5*8 +: 8] = 8'hA7;
        push_exp("mux_ch5", 32'hA7);
        tick(); tick();
        check(32'(bus.OUT_W));
        bus.SEL = 3'd2; bus.CH_W[2*8 +: 8] = 8'h3C;
        push_exp("mux_ch2", 32'h3C);
        tick(); tick();
        check(32'(bus.OUT_W));

        // T3 trigger on counting channel 0
        bus.SEL = 3'd0; bus.TRIG_VAL = 8'h10; bus.TRIG_MSK = 8'hFF; bus.POST = 4'd3;
        push_exp("t3_state", 3);
        push_exp("t3_out_w", 32'h10);
        push_exp("t3_hit_cnt", 1);
        for (int i = 0; i < 4; i++) push_exp($sformatf("t3_rd%0d", i), 32'(8'h13 - i));
        bus.CH_W[7:0] = 8'h00; bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        for (int v = 1; v < 40; v++) begin
            bus.CH_W[7:0] = 8'(v);
            tick();
        end
        check(32'(bus.STATE));
        check(32'(bus.OUT_W));
        check(32'(bus.HIT_CNT));
        for (int i = 0; i < 4; i++) begin
            bus.RD_IDX = 2'(i);
            tick();
            check(32'(bus.RD_W));
        end

        // T4 POST=0, mask 0: first armed sample triggers
        bus.CLR = 1'b1;
        push_exp("t4_clr_state", 0);
        tick();
        bus.CLR = 1'b0;
        check(32'(bus.STATE));
        bus.POST = 4'd0; bus.TRIG_MSK = 8'h00;
        bus.CH_W[7:0] = 8'h55; bus.CH_N[2:0] = 3'b101;
        push_exp("t4_state", 3);
        push_exp("t4_rd_w", 32'h55);
        push_exp("t4_rd_n", 5);
        push_exp("t4_hit_cnt", 2);
        push_exp("t4_out_w", 32'h55);
        bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        tick();
        check(32'(bus.STATE));
        bus.RD_IDX = 2'd0;
        tick();
        check(32'(bus.RD_W));
        check(32'(bus.RD_N));
        check(32'(bus.HIT_CNT));
        check(32'(bus.OUT_W));

        // T5 history wrap with POST > DEPTH
        RST = 1'b1;
        tick(); tick();
        RST = 1'b0;
        bus.SEL = 3'd0; bus.POST = 4'd9; bus.TRIG_VAL = 8'h40; bus.TRIG_MSK = 8'hFF;
        push_exp("t5_state", 3);
        push_exp("t5_out_w", 32'h40);
        push_exp("t5_hit_cnt", 1);
        for (int i = 0; i < 4; i++) push_exp($sformatf("t5_rd%0d", i), 32'(8'h49 - i));
        bus.CH_W[7:0] = 8'h30; bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        for (int v = 8'h31; v < 8'h60; v++) begin
            bus.CH_W[7:0] = 8'(v);
            tick();
        end
        check(32'(bus.STATE));
        check(32'(bus.OUT_W));
        check(32'(bus.HIT_CNT));
        for (int i = 0; i < 4; i++) begin
            bus.RD_IDX = 2'(i);
            tick();
            check(32'(bus.RD_W));
        end

        // T6 CLR+ARM in POST, then HIT_CNT saturation
        bus.POST = 4'd5; bus.TRIG_MSK = 8'h00;
        push_exp("t6_post_state", 2);
        bus.ARM = 1'b1;
        tick();
        bus.ARM = 1'b0;
        tick();
        check(32'(bus.STATE));
        push_exp("t6_clr_state", 0);
        push_exp("t6_clr_hit_cnt", 2);
        bus.CLR = 1'b1; bus.ARM = 1'b1;
        tick();
        bus.CLR = 1'b0; bus.ARM = 1'b0;
        check(32'(bus.STATE));
        check(32'(bus.HIT_CNT));
        bus.POST = 4'd0;
        exp_hits = 2;
        for (int i = 0; i < 16; i++) begin
            exp_hits = (exp_hits >= 15) ? 15 : exp_hits + 1;
            push_exp($sformatf("t6_sat_state%0d", i), 3);
            push_exp($sformatf("t6_sat_cnt%0d", i), exp_hits);
            bus.ARM = 1'b1;
            tick();
            bus.ARM = 1'b0;
            tick();
            check(32'(bus.STATE));
            check(32'(bus.HIT_CNT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
